// File: rtl/fp_sched_pkg.sv
// Shared types and helpers for the FP vector-add scheduler.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package fp_sched_pkg;

    localparam int DEF_EXP_BITS  = 5;
    localparam int DEF_MANT_BITS = 6;
    localparam int DEF_LANES     = 4;

    // The tag id is sized for the largest requester count this slice is
    // built for; raise MAX_NUM_REQ before instantiating more requesters.
    localparam int MAX_NUM_REQ = 2;
    localparam int TAG_ID_W    = (MAX_NUM_REQ > 1) ? $clog2(MAX_NUM_REQ) : 1;

    function automatic int fp_width(input int exp_bits, input int mant_bits);
        return 1 + exp_bits + mant_bits;
    endfunction

    function automatic int data_width(input int lanes, input int exp_bits, input int mant_bits);
        return lanes * fp_width(exp_bits, mant_bits);
    endfunction

    localparam int DEF_FP_W   = fp_width(DEF_EXP_BITS, DEF_MANT_BITS);
    localparam int DEF_DATA_W = data_width(DEF_LANES, DEF_EXP_BITS, DEF_MANT_BITS);

    // Tag travelling alongside a beat through the adder.
    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    // Lane 0 sits at the MSBs of a beat, lane LANES-1 at the LSBs.
    function automatic logic [DEF_FP_W-1:0] lane_slice(input logic [DEF_DATA_W-1:0] vec,
                                                        input int lane);
        return vec[(DEF_LANES-1-lane)*DEF_FP_W +: DEF_FP_W];
    endfunction

endpackage

// File: rtl/fp_rsp_fifo.sv
// Per-requester result FIFO: registered storage with an occupancy count.
// Latency: a pushed word is visible at the head the cycle after the push (no bypass).
// Backpressure: none internally; the caller's credits guarantee no push when full.
// Ports: clk/rst; push + push_data write; pop advances the head; head_data; count.
module fp_rsp_fifo #(
    parameter  int WIDTH = 48,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage carries no reset; only count decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

    // A push into a full FIFO is legal only when the head pops in the same cycle.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && count == CNT_W'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && count == '0));

endmodule

// File: rtl/fp_vadd_scheduler.sv
// Round-robin, credit-gated sharing of one fixed-latency vector adder among NUM_REQ requesters.
// Latency: grant/issue combinational in cycle T; result at FIFO head (rsp_valid) at T+DP_LATENCY+1.
// Backpressure: a requester is granted only while FIFO occupancy + in-flight beats < RSP_DEPTH.
// Ports: req_valid/req_ready/req_a/req_b (issue side, packed per requester), rsp_valid/rsp_ready/
//        rsp_data (per-requester results), dp_in_valid/dp_op1/dp_op2 and dp_out_valid/dp_out
//        (adder), busy and sticky tag_err.
module fp_vadd_scheduler
    import fp_sched_pkg::*;
#(
    parameter  int EXP_BITS   = 5,
    parameter  int MANT_BITS  = 6,
    parameter  int LANES      = 4,
    parameter  int NUM_REQ    = 2,
    parameter  int DP_LATENCY = 2,
    parameter  int RSP_DEPTH  = 4,
    localparam int FP_W       = fp_width(EXP_BITS, MANT_BITS),
    localparam int DATA_W     = data_width(LANES, EXP_BITS, MANT_BITS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [NUM_REQ*DATA_W-1:0] rsp_data,
    output logic                      dp_in_valid,
    output logic [DATA_W-1:0]         dp_op1,
    output logic [DATA_W-1:0]         dp_op2,
    input  logic                      dp_out_valid,
    input  logic [DATA_W-1:0]         dp_out,
    output logic                      busy,
    output logic                      tag_err
);

    localparam int              CNT_W   = $clog2(RSP_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RSP_DEPTH);

    logic [TAG_ID_W-1:0] rr_ptr;    // first requester considered next cycle
    logic                gnt_any;
    logic [TAG_ID_W-1:0] gnt_id;
    int                  idx;

    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  push;
    logic [NUM_REQ-1:0]  pop;
    logic [CNT_W-1:0]    fifo_cnt   [NUM_REQ];
    logic [CNT_W-1:0]    flight_cnt [NUM_REQ];
    logic [CNT_W-1:0]    credit     [NUM_REQ];
    logic [DATA_W-1:0]   head       [NUM_REQ];

    tag_t                tag_pipe   [DP_LATENCY];
    tag_t                tail;

    assign tail = tag_pipe[DP_LATENCY-1];

    // Credits are derived from the FIFO count plus the tags still in the
    // adder, so they can never drift from what is actually outstanding.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            flight_cnt[i] = '0;
            for (int s = 0; s < DP_LATENCY; s++) begin
                if (tag_pipe[s].valid && tag_pipe[s].id == TAG_ID_W'(i))
                    flight_cnt[i] = flight_cnt[i] + CNT_W'(1);
            end
            credit[i]   = fifo_cnt[i] + flight_cnt[i];
            eligible[i] = !rst && req_valid[i] && (credit[i] < CNT_MAX);
        end
    end

    // Round-robin search starting at rr_ptr, wrapping once.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!gnt_any && eligible[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = TAG_ID_W'(idx);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            req_ready[i] = gnt_any && (gnt_id == TAG_ID_W'(i));
    end

    assign dp_in_valid = gnt_any;
    assign dp_op1 = gnt_any ? req_a[int'(gnt_id)*DATA_W +: DATA_W] : '0;
    assign dp_op2 = gnt_any ? req_b[int'(gnt_id)*DATA_W +: DATA_W] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr  <= '0;
            tag_err <= 1'b0;
            for (int s = 0; s < DP_LATENCY; s++) tag_pipe[s] <= '0;
        end else begin
            if (gnt_any)
                rr_ptr <= (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + TAG_ID_W'(1);
            tag_pipe[0].valid <= gnt_any;
            tag_pipe[0].id    <= gnt_id;
            for (int s = 1; s < DP_LATENCY; s++) tag_pipe[s] <= tag_pipe[s-1];
            // Adder strobe disagreeing with the tag pipe means beats and tags
            // are out of step; flag it and keep the data out of the FIFOs.
            if (dp_out_valid != tail.valid) tag_err <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp
        assign push[g] = dp_out_valid && tail.valid && (tail.id == TAG_ID_W'(g));
        assign pop[g]  = rsp_valid[g] && rsp_ready[g];
        assign rsp_valid[g] = (fifo_cnt[g] != '0);
        assign rsp_data[g*DATA_W +: DATA_W] = head[g];

        fp_rsp_fifo #(
            .WIDTH (DATA_W),
            .DEPTH (RSP_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[g]),
            .push_data (dp_out),
            .pop       (pop[g]),
            .head_data (head[g]),
            .count     (fifo_cnt[g])
        );
    end

    always_comb begin
        busy = |rsp_valid;
        for (int s = 0; s < DP_LATENCY; s++) busy = busy | tag_pipe[s].valid;
    end

endmodule

// File: tb/tb_fp_vadd_scheduler.sv
// Bench for fp_vadd_scheduler: stand-in 2-cycle FP adder, queue-based reference model
// checked every cycle, plus directed scenarios with hand-computed expectations.
// Backpressure: rsp_ready is driven per scenario to stall or drain requesters.
module tb_fp_vadd_scheduler;
    import fp_sched_pkg::*;

    localparam int NREQ  = 2;
    localparam int DW    = 48;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NREQ*DW-1:0] req_a, req_b, rsp_data;
    logic            dp_in_valid, dp_out_valid, busy, tag_err;
    logic [DW-1:0]   dp_op1, dp_op2, dp_out;
    logic            inject;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_vadd_scheduler dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .dp_in_valid(dp_in_valid), .dp_op1(dp_op1), .dp_op2(dp_op2),
        .dp_out_valid(dp_out_valid), .dp_out(dp_out),
        .busy(busy), .tag_err(tag_err)
    );

    // Positive-normal FP add (1/5/6, bias 15), truncating alignment.
    function automatic logic [11:0] fp_add(input logic [11:0] x, input logic [11:0] y);
        logic [11:0] hi, lo;
        logic [4:0]  d;
        logic [7:0]  mh, ml, s;
        if (x[10:6] >= y[10:6]) begin hi = x; lo = y; end
        else begin hi = y; lo = x; end
        d  = hi[10:6] - lo[10:6];
        mh = {2'b01, hi[5:0]};
        ml = {2'b01, lo[5:0]} >> d;
        s  = mh + ml;
        if (s[7]) return {1'b0, hi[10:6] + 5'd1, s[6:1]};
        return {1'b0, hi[10:6], s[5:0]};
    endfunction

    function automatic logic [47:0] vadd(input logic [47:0] a, input logic [47:0] b);
        logic [47:0] r;
        for (int k = 0; k < 4; k++)
            r[(3-k)*12 +: 12] = fp_add(lane_slice(a, k), lane_slice(b, k));
        return r;
    endfunction

    // Stand-in adder: fixed 2-cycle latency, shares rst.
    logic        p1_v, p2_v;
    logic [47:0] p1_d, p2_d;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_v <= 1'b0; p2_v <= 1'b0; p1_d <= '0; p2_d <= '0;
        end else begin
            p1_v <= dp_in_valid; p1_d <= vadd(dp_op1, dp_op2);
            p2_v <= p1_v;        p2_d <= p1_d;
        end
    end
    assign dp_out_valid = p2_v | inject;
    assign dp_out       = p2_d;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [47:0] data;
        int          ready;
    } ent_t;

    ent_t mq [NREQ][$];
    int   cyc = 0;
    int   m_ptr = 0;
    logic m_err = 1'b0;

    always @(negedge clk) begin
        int          g;
        int          id;
        logic [1:0]  e_rdy, e_rv;
        logic [47:0] e_op1, e_op2;
        logic        e_busy;
        ent_t        e;
        if (rst) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_dp_in_valid", dp_in_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_tag_err", tag_err, 0);
            for (int i = 0; i < NREQ; i++) mq[i].delete();
            m_ptr = 0;
            m_err = 1'b0;
        end else begin
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                id = (m_ptr + k) % NREQ;
                if (g < 0 && req_valid[id] && mq[id].size() < DEPTH) g = id;
            end
            e_rdy = '0;
            e_op1 = '0;
            e_op2 = '0;
            if (g >= 0) begin
                e_rdy[g] = 1'b1;
                e_op1 = req_a[g*DW +: DW];
                e_op2 = req_b[g*DW +: DW];
            end
            chk("m_req_ready", req_ready, e_rdy);
            chk("m_dp_in_valid", dp_in_valid, g >= 0);
            chk("m_dp_op1", dp_op1, e_op1);
            chk("m_dp_op2", dp_op2, e_op2);
            e_busy = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                e_rv[i] = (mq[i].size() > 0) && (mq[i][0].ready <= cyc);
                if (mq[i].size() > 0) e_busy = 1'b1;
            end
            chk("m_rsp_valid", rsp_valid, e_rv);
            for (int i = 0; i < NREQ; i++)
                if (e_rv[i]) chk("m_rsp_data", rsp_data[i*DW +: DW], mq[i][0].data);
            chk("m_busy", busy, e_busy);
            chk("m_tag_err", tag_err, m_err);
            for (int i = 0; i < NREQ; i++)
                if (e_rv[i] && rsp_ready[i]) void'(mq[i].pop_front());
            if (g >= 0) begin
                e.data  = vadd(e_op1, e_op2);
                e.ready = cyc + 3;
                mq[g].push_back(e);
                m_ptr = (g + 1) % NREQ;
            end
            if (inject) m_err = 1'b1;
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    int         beat_no [NREQ];
    int         gnt_cnt [NREQ];
    logic [1:0] hs_seen;

    always @(negedge clk) begin
        hs_seen = req_valid & req_ready;
        if (!rst)
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) gnt_cnt[i]++;
    end

    task automatic load_operands(input int i);
        logic [47:0] a, b;
        for (int k = 0; k < 4; k++) begin
            a[(3-k)*12 +: 12] = {1'b0, 5'(8 + (beat_no[i] + i + k) % 8),
                                 6'((beat_no[i] * 7 + i * 13 + k * 3) % 64)};
            b[(3-k)*12 +: 12] = {1'b0, 5'(8 + (beat_no[i] + 2 * k) % 5),
                                 6'((beat_no[i] * 5 + k * 11 + i) % 64)};
        end
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
    endtask

    // Advance to just after the next rising edge; refresh accepted operands.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++)
            if (hs_seen[i]) begin
                beat_no[i]++;
                load_operands(i);
            end
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    int g1;

    initial begin
        rst = 1'b1; inject = 1'b0; rsp_ready = '0; req_a = '0; req_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            beat_no[i] = 0; gnt_cnt[i] = 0; load_operands(i);
        end
        req_valid = 2'b11;   // requests during reset must not be granted
        repeat (3) @(posedge clk);
        at_neg();
        chk("reset_req_ready", req_ready, 2'b00);
        chk("reset_busy", busy, 0);
        next_cycle(); rst = 1'b0; req_valid = '0; rsp_ready = 2'b11;
        next_cycle();

        // Single beat: 1.0 + 1.0 = 2.0 on every lane, response 3 cycles later.
        req_a[47:0] = {4{12'h3C0}}; req_b[47:0] = {4{12'h3C0}}; req_valid = 2'b01;
        at_neg();
        chk("single_ready", req_ready, 2'b01);
        chk("single_dp_in_valid", dp_in_valid, 1);
        chk("single_dp_op1", dp_op1, {4{12'h3C0}});
        next_cycle(); req_valid = '0;
        at_neg(); chk("single_t1_rsp_valid", rsp_valid, 2'b00);
        next_cycle(); at_neg(); chk("single_t2_rsp_valid", rsp_valid, 2'b00);
        next_cycle(); at_neg();
        chk("single_t3_rsp_valid", rsp_valid, 2'b01);
        chk("single_t3_rsp_data", rsp_data[47:0], {4{12'h400}});
        next_cycle(); at_neg();
        chk("single_idle_busy", busy, 0);

        // Contention: pointer sits after req0, so grants go 1,0,1,0,...
        next_cycle(); load_operands(0); load_operands(1); req_valid = 2'b11;
        for (int k = 0; k < 8; k++) begin
            at_neg();
            chk("contention_grant", req_ready, (k % 2 == 0) ? 2'b10 : 2'b01);
            chk("contention_dp_in_valid", dp_in_valid, 1);
            next_cycle();
        end
        req_valid = '0;
        repeat (6) next_cycle();
        at_neg(); chk("contention_drained_busy", busy, 0);

        // Credit stall on req1: 4 grants, then req0 owns the adder.
        next_cycle(); rsp_ready = 2'b01; req_valid = 2'b11; g1 = gnt_cnt[1];
        for (int k = 0; k < 16; k++) begin
            at_neg();
            if (k >= 10) chk("stall_req0_only", req_ready, 2'b01);
            next_cycle();
        end
        chk("stall_req1_grants", gnt_cnt[1] - g1, 4);
        chk("stall_req1_rsp_valid", rsp_valid[1], 1);

        // One pop frees exactly one credit.
        g1 = gnt_cnt[1]; rsp_ready = 2'b11;
        at_neg(); chk("pop_cycle_no_grant", req_ready, 2'b01);
        next_cycle(); rsp_ready = 2'b01;
        repeat (6) begin at_neg(); next_cycle(); end
        chk("pop_regrant", gnt_cnt[1] - g1, 1);

        // Release req1 at full credit: grants and pops overlap, alternating.
        g1 = gnt_cnt[1]; rsp_ready = 2'b11;
        repeat (10) begin at_neg(); next_cycle(); end
        chk("release_req1_grants", gnt_cnt[1] - g1, 5);
        req_valid = '0;
        repeat (10) next_cycle();
        at_neg(); chk("release_drained_busy", busy, 0);

        // Reset one cycle after a grant discards the in-flight beat.
        next_cycle(); req_valid = 2'b01;
        at_neg(); chk("rstmid_grant", dp_in_valid, 1);
        next_cycle(); req_valid = '0; rst = 1'b1;
        next_cycle();
        next_cycle(); rst = 1'b0;
        at_neg(); chk("rstmid_rsp_valid", rsp_valid, 2'b00); chk("rstmid_busy", busy, 0);
        next_cycle(); at_neg(); chk("rstmid_rsp_valid_late", rsp_valid, 2'b00);
        next_cycle(); req_valid = 2'b01;
        next_cycle(); req_valid = '0;
        next_cycle();
        next_cycle(); at_neg(); chk("post_rst_rsp_valid", rsp_valid, 2'b01);
        next_cycle();

        // Adder strobe with nothing in flight.
        next_cycle(); inject = 1'b1;
        next_cycle(); inject = 1'b0;
        at_neg();
        chk("perr_set", tag_err, 1);
        chk("perr_no_write", rsp_valid, 2'b00);
        chk("perr_busy", busy, 0);
        repeat (5) next_cycle();
        at_neg(); chk("perr_sticky", tag_err, 1);
        next_cycle(); rst = 1'b1;
        at_neg(); chk("perr_cleared", tag_err, 0);
        next_cycle(); rst = 1'b0;
        repeat (3) next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
